conv1d_window_ram: RTL and testbench

Parametrised multi-channel feature-map buffer for the CONV1D pipeline stages. Stores a `CHANNELS × LENGTH` map of signed words, one word written per cycle. Returns a zero-padded `KERNEL`-tap window centred on any position, either on demand or through a built-in channel-major scan sequencer. Sits between a layer's output writer and the next CONV1D MAC array, with valid/ready backpressure on the window output.

---
 rtl/conv1d_window_ram_if.sv | 36 +++
 rtl/conv1d_window_ram.sv | 136 +++++++++++++
 tb/tb_conv1d_window_ram.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv1d_window_ram_if.sv
// Write, read-request, scan-control and window-output signals of conv1d_window_ram.
// master drives requests and Out_Ready. slave is the buffer itself.
interface conv1d_window_ram_if #(
  parameter int Bit_width = 16,
  parameter int KERNEL    = 3,
  parameter int CH_W      = 3,
  parameter int POS_W     = 8
);
  logic                        Write_Enable;
  logic [CH_W-1:0]             Write_Depth;
  logic [POS_W-1:0]            Write_Width;
  logic [Bit_width-1:0]        data_in;
  logic                        Read_Enable;
  logic [CH_W-1:0]             Read_Depth;
  logic [POS_W-1:0]            Read_Width;
  logic                        Scan_Start;
  logic                        Scan_Busy;
  logic                        Scan_Done;
  logic                        Out_Valid;
  logic                        Out_Ready;
  logic [CH_W-1:0]             Out_Depth;
  logic [POS_W-1:0]            Out_Width;
  logic [KERNEL*Bit_width-1:0] data_out;

  modport master (
    output Write_Enable, Write_Depth, Write_Width, data_in,
    output Read_Enable, Read_Depth, Read_Width, Scan_Start, Out_Ready,
    input  Scan_Busy, Scan_Done, Out_Valid, Out_Depth, Out_Width, data_out
  );

  modport slave (
    input  Write_Enable, Write_Depth, Write_Width, data_in,
    input  Read_Enable, Read_Depth, Read_Width, Scan_Start, Out_Ready,
    output Scan_Busy, Scan_Done, Out_Valid, Out_Depth, Out_Width, data_out
  );
endinterface

// File: rtl/conv1d_window_ram.sv
// CHANNELS x LENGTH feature-map RAM that returns zero-padded KERNEL-tap windows, on demand or by scan.
// Define CONV1D_WINDOW_RAM_WRITE_FWD_EN to forward a same-cycle write into the window being loaded.
module conv1d_window_ram #(
  parameter int Bit_width = 16,
  parameter int CHANNELS  = 8,
  parameter int LENGTH    = 256,
  parameter int KERNEL    = 3,
  parameter int CH_W      = $clog2(CHANNELS),
  parameter int POS_W     = $clog2(LENGTH)
) (
  input logic               CLK,
  input logic               RST,
  conv1d_window_ram_if.slave bus
);
  localparam int HALF = (KERNEL - 1) / 2;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(LENGTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t                      state, state_n;
  logic [CH_W-1:0]             scan_ch, scan_ch_n, sel_ch;
  logic [POS_W-1:0]            scan_pos, scan_pos_n, sel_pos;
  logic                        load, advance, done_n;
  logic                        out_valid, scan_done;
  logic [CH_W-1:0]             out_depth;
  logic [POS_W-1:0]            out_width;
  logic [KERNEL*Bit_width-1:0] out_data, window;
  logic                        window_ok;
  int                          tap;

  logic [Bit_width-1:0] mem [CHANNELS][LENGTH];

  always_ff @(posedge CLK) begin
    if (bus.Write_Enable && int'(bus.Write_Depth) < CHANNELS && int'(bus.Write_Width) < LENGTH)
      mem[bus.Write_Depth][bus.Write_Width] <= bus.data_in;
  end

  // Out-of-range channel or centre gives an all-zero window; edge taps pad with zero.
  always_comb begin
    window    = '0;
    tap       = 0;
    window_ok = (int'(sel_ch) < CHANNELS) && (int'(sel_pos) < LENGTH);
    for (int unsigned k = 0; k < KERNEL; k++) begin
      tap = int'(sel_pos) - HALF + int'(k);
      if (window_ok && tap >= 0 && tap < LENGTH) begin
        window[k*Bit_width +: Bit_width] = mem[sel_ch][tap[POS_W-1:0]];
`ifdef CONV1D_WINDOW_RAM_WRITE_FWD_EN
        if (bus.Write_Enable && bus.Write_Depth == sel_ch && int'(bus.Write_Width) == tap)
          window[k*Bit_width +: Bit_width] = bus.data_in;
`endif
      end
    end
  end

  assign advance = !out_valid || bus.Out_Ready;

  always_comb begin
    state_n    = state;
    scan_ch_n  = scan_ch;
    scan_pos_n = scan_pos;
    sel_ch     = bus.Read_Depth;
    sel_pos    = bus.Read_Width;
    load       = 1'b0;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Scan_Start) begin
          state_n    = SCAN;
          scan_ch_n  = '0;
          scan_pos_n = '0;
        end else if (bus.Read_Enable && advance) begin
          load = 1'b1;
        end
      end
      SCAN: begin
        sel_ch  = scan_ch;
        sel_pos = scan_pos;
        if (advance) begin
          load = 1'b1;
          if (scan_pos == LAST_POS) begin
            scan_pos_n = '0;
            if (scan_ch == LAST_CH) begin
              state_n   = DRAIN;
              scan_ch_n = '0;
            end else begin
              scan_ch_n = scan_ch + CH_W'(1);
            end
          end else begin
            scan_pos_n = scan_pos + POS_W'(1);
          end
        end
      end
      DRAIN: begin
        if (out_valid && bus.Out_Ready) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      scan_ch   <= '0;
      scan_pos  <= '0;
      out_valid <= 1'b0;
      scan_done <= 1'b0;
      out_depth <= '0;
      out_width <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      scan_ch   <= scan_ch_n;
      scan_pos  <= scan_pos_n;
      scan_done <= done_n;
      if (advance) begin
        out_valid <= load;
        if (load) begin
          out_depth <= sel_ch;
          out_width <= sel_pos;
          out_data  <= window;
        end
      end
    end
  end

  assign bus.Scan_Busy = (state != IDLE);
  assign bus.Scan_Done = scan_done;
  assign bus.Out_Valid = out_valid;
  assign bus.Out_Depth = out_depth;
  assign bus.Out_Width = out_width;
  assign bus.data_out  = out_data;
endmodule

// File: tb/tb_conv1d_window_ram.sv
// Randomised directed bench for conv1d_window_ram against an array model of the feature map.
// Small non-power-of-two geometry so out-of-range channel and position codes exist.
module tb_conv1d_window_ram;
  localparam int BW = 16;
  localparam int CH = 3;
  localparam int L  = 6;
  localparam int K  = 3;
  localparam int CW = 2;
  localparam int PW = 3;
  localparam int NWIN = CH * L;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv1d_window_ram_if #(.Bit_width(BW), .KERNEL(K), .CH_W(CW), .POS_W(PW)) bus ();

  conv1d_window_ram #(
    .Bit_width(BW), .CHANNELS(CH), .LENGTH(L), .KERNEL(K), .CH_W(CW), .POS_W(PW)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [BW-1:0] model [CH][L];

  function automatic logic [K*BW-1:0] model_win(input int ch, input int c);
    logic [K*BW-1:0] w = '0;
    if (ch < CH && c < L)
      for (int k = 0; k < K; k++) begin
        int p = c - (K - 1) / 2 + k;
        if (p >= 0 && p < L) w[k*BW +: BW] = model[ch][p];
      end
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_win(input string tag, input int ch, input int c, input logic [K*BW-1:0] w);
    check({tag, "_valid"}, 64'(bus.Out_Valid), 64'd1);
    check({tag, "_depth"}, 64'(bus.Out_Depth), 64'(ch));
    check({tag, "_width"}, 64'(bus.Out_Width), 64'(c));
    check({tag, "_data"},  64'(bus.data_out),  64'(w));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.Write_Enable = 1'b0;
    bus.Write_Depth  = '0;
    bus.Write_Width  = '0;
    bus.data_in      = '0;
    bus.Read_Enable  = 1'b0;
    bus.Read_Depth   = '0;
    bus.Read_Width   = '0;
    bus.Scan_Start   = 1'b0;
    bus.Out_Ready    = 1'b0;
  endtask

  task automatic direct_read(input string tag, input int ch, input int c);
    bus.Read_Enable = 1'b1;
    bus.Read_Depth  = CW'(ch);
    bus.Read_Width  = PW'(c);
    bus.Out_Ready   = 1'b1;
    step();
    bus.Read_Enable = 1'b0;
    check_win(tag, ch, c, model_win(ch, c));
  endtask

  initial begin
    int ch, c, idx, stall, cycles;
    bit seen;
    logic [BW-1:0] nv;
    logic [K*BW-1:0] w;

    rst = 1'b1;
    idle();
    step();
    step();
    check("rst_valid", 64'(bus.Out_Valid), 64'd0);
    check("rst_busy",  64'(bus.Scan_Busy), 64'd0);
    check("rst_done",  64'(bus.Scan_Done), 64'd0);
    check("rst_depth", 64'(bus.Out_Depth), 64'd0);
    check("rst_width", 64'(bus.Out_Width), 64'd0);
    check("rst_data",  64'(bus.data_out),  64'd0);
    rst = 1'b0;

    for (int i = 0; i < CH; i++)
      for (int p = 0; p < L; p++) begin
        model[i][p]      = BW'($urandom);
        bus.Write_Enable = 1'b1;
        bus.Write_Depth  = CW'(i);
        bus.Write_Width  = PW'(p);
        bus.data_in      = model[i][p];
        step();
      end

    // Writes outside the map must leave it untouched.
    for (int i = 0; i < 8; i++) begin
      bus.Write_Enable = 1'b1;
      bus.Write_Depth  = (i < 6) ? CW'(CH) : CW'(i - 6);
      bus.Write_Width  = (i < 6) ? PW'(i) : PW'(L + (i & 1));
      bus.data_in      = BW'($urandom);
      step();
    end
    bus.Write_Enable = 1'b0;

    for (int i = 0; i < 12; i++) begin
      case (i)
        0: begin ch = 0; c = 0; end
        1: begin ch = 0; c = L - 1; end
        2: begin ch = 2; c = 0; end
        3: begin ch = 2; c = L - 1; end
        4: begin ch = 1; c = L; end
        5: begin ch = CH; c = 2; end
        default: begin ch = $urandom_range(0, CH - 1); c = $urandom_range(0, L - 1); end
      endcase
      direct_read("rd", ch, c);
    end
    step();
    check("rd_idle_valid", 64'(bus.Out_Valid), 64'd0);

    // Request held under backpressure: first window stays until the consumer accepts.
    bus.Read_Enable = 1'b1; bus.Read_Depth = 2'd1; bus.Read_Width = 3'd1; bus.Out_Ready = 1'b0;
    step();
    check_win("bp_first", 1, 1, model_win(1, 1));
    bus.Read_Width = 3'd3;
    step();
    check_win("bp_hold1", 1, 1, model_win(1, 1));
    step();
    check_win("bp_hold2", 1, 1, model_win(1, 1));
    bus.Out_Ready = 1'b1;
    step();
    bus.Read_Enable = 1'b0;
    check_win("bp_next", 1, 3, model_win(1, 3));
    step();
    check("bp_drain_valid", 64'(bus.Out_Valid), 64'd0);

    // Same-cycle write into the window being loaded.
    nv = ~model[0][3];
    bus.Write_Enable = 1'b1; bus.Write_Depth = 2'd0; bus.Write_Width = 3'd3; bus.data_in = nv;
    bus.Read_Enable  = 1'b1; bus.Read_Depth  = 2'd0; bus.Read_Width  = 3'd2;
    step();
    idle();
    bus.Out_Ready = 1'b1;
    w = model_win(0, 2);
`ifdef CONV1D_WINDOW_RAM_WRITE_FWD_EN
    w[2*BW +: BW] = nv;
`endif
    check_win("haz", 0, 2, w);
    model[0][3] = nv;
    nv = ~model[1][3];
    bus.Write_Enable = 1'b1; bus.Write_Depth = 2'd1; bus.Write_Width = 3'd3; bus.data_in = nv;
    bus.Read_Enable  = 1'b1; bus.Read_Depth  = 2'd0; bus.Read_Width  = 3'd2;
    step();
    idle();
    bus.Out_Ready = 1'b1;
    check_win("haz_otherch", 0, 2, model_win(0, 2));
    model[1][3] = nv;
    direct_read("haz_after", 0, 2);
    direct_read("haz_after_ch1", 1, 4);

    // Full scan with the consumer always ready; a same-cycle read is dropped in favour of the scan.
    bus.Scan_Start = 1'b1; bus.Read_Enable = 1'b1; bus.Read_Depth = 2'd1; bus.Read_Width = 3'd1;
    bus.Out_Ready = 1'b1;
    step();
    bus.Scan_Start = 1'b0; bus.Read_Enable = 1'b0;
    check("scan1_rd_drop", 64'(bus.Out_Valid), 64'd0);
    check("scan1_busy0", 64'(bus.Scan_Busy), 64'd1);
    for (int i = 0; i < NWIN; i++) begin
      if (i < NWIN - 3) begin
        bus.Scan_Start  = 1'($urandom_range(0, 1));
        bus.Read_Enable = 1'($urandom_range(0, 1));
        bus.Read_Depth  = CW'($urandom_range(0, CH - 1));
        bus.Read_Width  = PW'($urandom_range(0, L - 1));
      end
      step();
      bus.Scan_Start = 1'b0; bus.Read_Enable = 1'b0;
      check_win("scan1", i / L, i % L, model_win(i / L, i % L));
      check("scan1_busy", 64'(bus.Scan_Busy), 64'd1);
      check("scan1_done", 64'(bus.Scan_Done), 64'd0);
    end
    step();
    check("scan1_done_pulse", 64'(bus.Scan_Done), 64'd1);
    check("scan1_busy_fall",  64'(bus.Scan_Busy), 64'd0);
    check("scan1_end_valid",  64'(bus.Out_Valid), 64'd0);
    step();
    check("scan1_done_clear", 64'(bus.Scan_Done), 64'd0);

    // Scan under random backpressure, with a forced 3-cycle stall at window (0,2).
    bus.Scan_Start = 1'b1; bus.Out_Ready = 1'b0;
    step();
    bus.Scan_Start = 1'b0;
    idx = 0; stall = 0; cycles = 0; seen = 1'b0;
    while (idx < NWIN && cycles < 400) begin
      cycles++;
      if (bus.Out_Valid) begin
        seen = 1'b1;
        check_win("scan2", idx / L, idx % L, model_win(idx / L, idx % L));
      end else if (seen) begin
        check("scan2_gap", 64'(bus.Out_Valid), 64'd1);
      end
      if (bus.Out_Valid && idx == 2 && stall < 3) begin
        bus.Out_Ready = 1'b0;
        stall++;
      end else begin
        bus.Out_Ready = ($urandom_range(0, 3) != 0);
      end
      if (bus.Out_Valid && bus.Out_Ready) idx++;
      step();
    end
    check("scan2_budget", 64'(idx), 64'(NWIN));
    check("scan2_done_pulse", 64'(bus.Scan_Done), 64'd1);
    check("scan2_busy_fall",  64'(bus.Scan_Busy), 64'd0);
    bus.Out_Ready = 1'b1;
    step();
    check("scan2_done_clear", 64'(bus.Scan_Done), 64'd0);

    // Reset in the middle of a scan.
    bus.Scan_Start = 1'b1;
    step();
    bus.Scan_Start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_win("scan3_w3", 0, 3, model_win(0, 3));
    rst = 1'b1;
    step();
    check("mrst_valid", 64'(bus.Out_Valid), 64'd0);
    check("mrst_busy",  64'(bus.Scan_Busy), 64'd0);
    check("mrst_done",  64'(bus.Scan_Done), 64'd0);
    rst = 1'b0;
    step();
    check("mrst_done2",  64'(bus.Scan_Done), 64'd0);
    check("mrst_valid2", 64'(bus.Out_Valid), 64'd0);
    check("mrst_busy2",  64'(bus.Scan_Busy), 64'd0);
    direct_read("mrst_rd", 1, 2);
    direct_read("mrst_rd_edge", 2, L - 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
